// File: rtl/calc_input_controller.sv
// calc_input_controller
//   Turns keypad tokens into stack-calculator commands. Digit keys build a
//   decimal operand. Enter and operator keys issue PUSH and/or arithmetic
//   commands over a valid/ready handshake.
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   token[3:0]      0-9 digit, A add, B sub, C mul, D enter, E clear, F drop
//   token_valid     level flag; only its rising edge accepts a token
//   cmd_valid/ready handshake to the stack unit
//   cmd_op[2:0]     000 PUSH, 001 ADD, 010 SUB, 011 MUL, 100 DROP
//   cmd_data        PUSH operand, otherwise 0
//   entry_value     operand being typed (drives the display)
//   entry_active    at least one digit since the last push/clear
//   token_drop      one-cycle pulse when a token is discarded
module calc_input_controller #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       token,
    input  logic             token_valid,
    output logic             cmd_valid,
    output logic [2:0]       cmd_op,
    output logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_ready,
    output logic [WIDTH-1:0] entry_value,
    output logic             entry_active,
    output logic             token_drop
);

    typedef enum logic [1:0] {IDLE, ISSUE_PUSH, ISSUE_OP} state_t;

    localparam logic [2:0] OP_PUSH = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_DROP = 3'b100;

    state_t           state;
    logic             tv_d;
    logic [2:0]       pend_op;
    logic             has_op;

    logic             tok_edge;
    logic [WIDTH+3:0] ext;
    logic [WIDTH+3:0] next_val;
    logic             ovf;
    logic [2:0]       tok_op;

    assign tok_edge = token_valid & ~tv_d;

    // entry*10 + digit as shift-and-add; 4 extra bits cover the worst case
    assign ext      = {4'b0000, entry_value};
    assign next_val = (ext << 3) + (ext << 1) + {{WIDTH{1'b0}}, token};
    assign ovf      = |next_val[WIDTH+3:WIDTH];

    always_comb begin
        tok_op = OP_DROP;
        case (token)
            4'hA:    tok_op = OP_ADD;
            4'hB:    tok_op = OP_SUB;
            4'hC:    tok_op = OP_MUL;
            default: tok_op = OP_DROP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            // loading the live level means a key already held at reset
            // release is never taken as a fresh press
            tv_d         <= token_valid;
            pend_op      <= OP_PUSH;
            has_op       <= 1'b0;
            cmd_valid    <= 1'b0;
            cmd_op       <= OP_PUSH;
            cmd_data     <= '0;
            entry_value  <= '0;
            entry_active <= 1'b0;
            token_drop   <= 1'b0;
        end else begin
            tv_d       <= token_valid;
            token_drop <= 1'b0;
            case (state)
                IDLE: begin
                    if (tok_edge) begin
                        if (token <= 4'd9) begin
                            if (ovf) begin
                                token_drop <= 1'b1;
                            end else begin
                                entry_value  <= next_val[WIDTH-1:0];
                                entry_active <= 1'b1;
                            end
                        end else if (token == 4'hE) begin
                            entry_value  <= '0;
                            entry_active <= 1'b0;
                        end else if (token == 4'hD) begin
                            // enter with nothing typed is silently ignored
                            if (entry_active) begin
                                state     <= ISSUE_PUSH;
                                has_op    <= 1'b0;
                                cmd_valid <= 1'b1;
                                cmd_op    <= OP_PUSH;
                                cmd_data  <= entry_value;
                            end
                        end else begin
                            pend_op <= tok_op;
                            if (entry_active) begin
                                // flush the typed operand before the operator
                                state     <= ISSUE_PUSH;
                                has_op    <= 1'b1;
                                cmd_valid <= 1'b1;
                                cmd_op    <= OP_PUSH;
                                cmd_data  <= entry_value;
                            end else begin
                                state     <= ISSUE_OP;
                                has_op    <= 1'b0;
                                cmd_valid <= 1'b1;
                                cmd_op    <= tok_op;
                                cmd_data  <= '0;
                            end
                        end
                    end
                end
                ISSUE_PUSH: begin
                    if (tok_edge) token_drop <= 1'b1;
                    if (cmd_ready) begin
                        entry_value  <= '0;
                        entry_active <= 1'b0;
                        cmd_data     <= '0;
                        if (has_op) begin
                            // cmd_valid stays high: back-to-back op
                            state  <= ISSUE_OP;
                            cmd_op <= pend_op;
                            has_op <= 1'b0;
                        end else begin
                            state     <= IDLE;
                            cmd_valid <= 1'b0;
                            cmd_op    <= OP_PUSH;
                        end
                    end
                end
                ISSUE_OP: begin
                    if (tok_edge) token_drop <= 1'b1;
                    if (cmd_ready) begin
                        state     <= IDLE;
                        cmd_valid <= 1'b0;
                        cmd_op    <= OP_PUSH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_input_controller.sv
// Directed bench for calc_input_controller (WIDTH=16). Inputs are driven and
// outputs sampled on the falling edge, away from the active rising edge.
module tb_calc_input_controller;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       token;
    logic             token_valid;
    logic             cmd_valid;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_ready;
    logic [WIDTH-1:0] entry_value;
    logic             entry_active;
    logic             token_drop;

    int total = 0;
    int bad   = 0;

    calc_input_controller #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .token        (token),
        .token_valid  (token_valid),
        .cmd_valid    (cmd_valid),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .cmd_ready    (cmd_ready),
        .entry_value  (entry_value),
        .entry_active (entry_active),
        .token_drop   (token_drop)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // one key: held high for 'hold' cycles, then low for 'low' cycles
    task automatic press(input logic [3:0] t, input int hold, input int low);
        token       = t;
        token_valid = 1'b1;
        tick(hold);
        token_valid = 1'b0;
        tick(low);
    endtask

    initial begin
        rst         = 1'b1;
        token       = 4'h0;
        token_valid = 1'b0;
        cmd_ready   = 1'b0;
        tick(2);
        chk("rst_valid", cmd_valid, 0);
        chk("rst_entry", entry_value, 0);
        chk("rst_active", entry_active, 0);
        chk("rst_drop", token_drop, 0);
        rst = 1'b0;
        tick(1);

        // digits 1,2,3 then a long hold of 4
        press(4'd1, 5, 5);
        press(4'd2, 5, 5);
        press(4'd3, 5, 5);
        chk("d123_entry", entry_value, 123);
        chk("d123_active", entry_active, 1);
        chk("d123_valid", cmd_valid, 0);
        press(4'd4, 50, 2);
        chk("hold_entry", entry_value, 1234);
        press(4'hE, 1, 1);
        chk("clr_entry", entry_value, 0);
        chk("clr_active", entry_active, 0);

        // 42 then enter, ready held high
        cmd_ready = 1'b1;
        press(4'd4, 1, 1);
        press(4'd2, 1, 1);
        token = 4'hD; token_valid = 1'b1;
        tick(1);
        chk("ent_valid", cmd_valid, 1);
        chk("ent_op", cmd_op, 0);
        chk("ent_data", cmd_data, 42);
        tick(1);
        chk("ent_valid_off", cmd_valid, 0);
        chk("ent_entry_clr", entry_value, 0);
        chk("ent_active_clr", entry_active, 0);
        token_valid = 1'b0;
        tick(1);

        // 7 then A, stalled 4 cycles
        cmd_ready = 1'b0;
        press(4'd7, 1, 1);
        token = 4'hA; token_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("stall_valid", cmd_valid, 1);
            chk("stall_op", cmd_op, 0);
            chk("stall_data", cmd_data, 7);
        end
        cmd_ready = 1'b1;
        tick(1);
        chk("add_valid", cmd_valid, 1);
        chk("add_op", cmd_op, 1);
        chk("add_data", cmd_data, 0);
        chk("add_entry", entry_value, 0);
        tick(1);
        chk("add_done", cmd_valid, 0);
        token_valid = 1'b0;
        tick(1);

        // saturation at 65535
        press(4'd6, 1, 1);
        press(4'd5, 1, 1);
        press(4'd5, 1, 1);
        press(4'd3, 1, 1);
        press(4'd5, 1, 1);
        chk("max_entry", entry_value, 65535);
        token = 4'd6; token_valid = 1'b1;
        tick(1);
        chk("ovf_drop", token_drop, 1);
        chk("ovf_entry", entry_value, 65535);
        tick(1);
        chk("ovf_drop_off", token_drop, 0);
        token_valid = 1'b0;
        tick(1);
        press(4'hE, 1, 1);
        token = 4'hB; token_valid = 1'b1;
        tick(1);
        chk("sub_valid", cmd_valid, 1);
        chk("sub_op", cmd_op, 2);
        chk("sub_data", cmd_data, 0);
        tick(1);
        chk("sub_done", cmd_valid, 0);
        token_valid = 1'b0;
        tick(1);

        // busy: C pressed while PUSH/9 stalled
        cmd_ready = 1'b0;
        press(4'd9, 1, 1);
        token = 4'hA; token_valid = 1'b1;
        tick(1);
        token_valid = 1'b0;
        tick(1);
        token = 4'hC; token_valid = 1'b1;
        tick(1);
        chk("busy_drop", token_drop, 1);
        chk("busy_op", cmd_op, 0);
        chk("busy_data", cmd_data, 9);
        chk("busy_entry", entry_value, 9);
        token_valid = 1'b0;
        cmd_ready   = 1'b1;
        tick(1);
        chk("busy_drop_off", token_drop, 0);
        chk("busy_op2", cmd_op, 1);
        chk("busy_valid2", cmd_valid, 1);
        tick(1);
        chk("busy_done", cmd_valid, 0);
        tick(1);
        chk("busy_no_extra", cmd_valid, 0);

        // reset while PUSH/99 stalled
        cmd_ready = 1'b0;
        press(4'd9, 1, 1);
        press(4'd9, 1, 1);
        token = 4'hA; token_valid = 1'b1;
        tick(1);
        token_valid = 1'b0;
        tick(1);
        chk("pre_rst_data", cmd_data, 99);
        chk("pre_rst_entry", entry_value, 99);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_rst_valid", cmd_valid, 0);
        chk("mid_rst_entry", entry_value, 0);
        chk("mid_rst_active", entry_active, 0);
        cmd_ready = 1'b1;
        token = 4'hD; token_valid = 1'b1;
        tick(1);
        chk("d_ignored", cmd_valid, 0);
        chk("d_no_drop", token_drop, 0);
        token_valid = 1'b0;
        tick(1);

        // reset while ISSUE_OP stalled
        cmd_ready = 1'b0;
        token = 4'hF; token_valid = 1'b1;
        tick(1);
        chk("drop_op", cmd_op, 4);
        chk("drop_valid", cmd_valid, 1);
        token_valid = 1'b0;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("op_rst_valid", cmd_valid, 0);
        chk("op_rst_op", cmd_op, 0);

        // token edge coincident with reset is swallowed
        rst = 1'b1; token = 4'd5; token_valid = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(2);
        chk("rst_edge_entry", entry_value, 0);
        chk("rst_edge_active", entry_active, 0);
        token_valid = 1'b0;
        tick(1);
        press(4'd5, 1, 1);
        chk("post_rst_digit", entry_value, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
